// File: rtl/dffram_regfile_nr1w.sv
`default_nettype none
// ============================================================================
//  Module      : dffram_regfile_nr1w
//  Description : Flip-flop based register file with NRD independent read
//                ports and one lane-masked write port. Each read port can be
//                combinational or registered. An optional write-through
//                bypass merges the in-flight write into same-address reads.
//                A clear engine zeroes the array after reset or on request.
//                Writes to an out-of-range address, or writes made while a
//                clear is running, are dropped and set a sticky error flag.
//  Ports       : clk        rising-edge clock
//                rst        asynchronous reset, active high
//                wr_en      write request
//                wr_addr    write address
//                wr_data    write data
//                wr_mask    per-lane write enables
//                rd_addr    packed read addresses, port p at [p*AWIDTH +: AWIDTH]
//                rd_data    packed read data,      port p at [p*DWIDTH +: DWIDTH]
//                cfg_rdbuf  per port: 1 = registered read, 0 = combinational read
//                cfg_wt     write-through bypass enable (all ports)
//                clr_req    start a clear sweep
//                busy       clear sweep in progress
//                wr_err     sticky: a write was dropped
//                err_clr    clears wr_err
//  Revision    : 1.0  initial release
// ============================================================================
module dffram_regfile_nr1w #(
    parameter int AWIDTH = 5,
    parameter int DEPTH  = 20,
    parameter int DWIDTH = 8,
    parameter int LANEW  = 4,
    parameter int NRD    = 2,
    localparam int LANES = DWIDTH / LANEW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AWIDTH-1:0]        wr_addr,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic [LANES-1:0]         wr_mask,
    input  logic [NRD*AWIDTH-1:0]    rd_addr,
    output logic [NRD*DWIDTH-1:0]    rd_data,
    input  logic [NRD-1:0]           cfg_rdbuf,
    input  logic                     cfg_wt,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_err,
    input  logic                     err_clr
);

    localparam logic [0:0]        c_st_idle  = 1'b0;
    localparam logic [0:0]        c_st_clear = 1'b1;
    // One extra bit so DEPTH == 2**AWIDTH still compares correctly.
    localparam logic [AWIDTH:0]   c_depth    = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] c_last_ptr = AWIDTH'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [AWIDTH-1:0] r_ptr;
    logic              r_err;
    logic [DWIDTH-1:0] r_mem [DEPTH];

    logic w_busy;
    logic w_wr_in_range;
    logic w_wr_go;
    logic w_wr_drop;

    assign w_busy        = (r_state == c_st_clear);
    assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
    assign w_wr_go       = wr_en & ~w_busy & w_wr_in_range;
    assign w_wr_drop     = wr_en & (w_busy | ~w_wr_in_range);

    assign busy   = w_busy;
    assign wr_err = r_err;

    // ------------------------------------------------------------------
    // Clear engine. Reset parks the FSM in CLEAR with the pointer at 0,
    // so the sweep restarts from scratch whenever rst is pulsed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_clear;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (clr_req) begin
                        r_state <= c_st_clear;
                        r_ptr   <= '0;
                    end
                end
                c_st_clear: begin
                    // clr_req is ignored here: an active sweep never restarts.
                    if (r_ptr == c_last_ptr) begin
                        r_state <= c_st_idle;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_clear;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // Sticky drop flag; a new drop in the same cycle beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_wr_drop) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Not reset: the sweep zeroes it. While rst is high the FSM
    // is held in CLEAR, so user writes are blocked by w_busy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_go) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l]) begin
                    r_mem[wr_addr][l*LANEW +: LANEW] <= wr_data[l*LANEW +: LANEW];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AWIDTH-1:0] w_addr;
        logic              w_in_range;
        logic              w_hit;
        logic [DWIDTH-1:0] w_curr;
        logic [DWIDTH-1:0] r_buf;

        assign w_addr     = rd_addr[p*AWIDTH +: AWIDTH];
        assign w_in_range = ({1'b0, w_addr} < c_depth);
        assign w_hit      = cfg_wt & w_wr_go & (wr_addr == w_addr);

        // Out-of-range addresses return zero rather than aliasing a word.
        always_comb begin
            w_curr = '0;
            if (!w_busy && w_in_range) begin
                w_curr = r_mem[w_addr];
                if (w_hit) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (wr_mask[l]) begin
                            w_curr[l*LANEW +: LANEW] = wr_data[l*LANEW +: LANEW];
                        end
                    end
                end
            end
        end

        // Loads every cycle, including during a sweep, so it reads zero
        // one cycle after busy rises.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_buf <= '0;
            end else begin
                r_buf <= w_curr;
            end
        end

        assign rd_data[p*DWIDTH +: DWIDTH] = cfg_rdbuf[p] ? r_buf : w_curr;
    end

endmodule
`default_nettype wire
